// File: rtl/lcd_bus_responder.sv
// Display-side model of an HD44780-compatible character LCD: decodes the
// rs/rw/enable/data bus and keeps DDRAM, CGRAM, the address counter and mode flags.
module lcd_bus_responder #(
  parameter int unsigned EXEC_CYCLES  = 4,
  parameter int unsigned CLEAR_CYCLES = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs,
  input  logic       rw,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [6:0] disp_addr,
  output logic [7:0] disp_char,
  input  logic [5:0] cg_addr,
  output logic [4:0] cg_row,
  output logic [6:0] ac,
  output logic       ac_is_cgram,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       two_line,
  output logic       busy,
  output logic       overrun,
  output logic       cmd_strobe
);

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

  state_t      state;
  logic [10:0] sync1, sync2;
  logic        en3;
  logic [15:0] cnt;
  logic [6:0]  sweep;

  logic [7:0]  ddram [0:79];
  logic [4:0]  cgram [0:63];

  logic        s_en, s_rs, s_rw;
  logic [7:0]  s_data;
  logic        fall, wr_acc, wr_ovr, rd_step;
  logic [6:0]  ac_stepped;
  logic [7:0]  rd_byte;

  logic        dd_we, cg_we;
  logic [6:0]  dd_waddr;
  logic [7:0]  dd_wdata;
  logic [5:0]  cg_waddr;
  logic [4:0]  cg_wdata;

  function automatic logic dd_valid(input logic [6:0] a);
    return a[5:0] < 6'd40;
  endfunction

  // Two 40-cell lines packed into one 80-entry array.
  function automatic logic [6:0] dd_index(input logic [6:0] a);
    return a[6] ? 7'd40 + {1'b0, a[5:0]} : {1'b0, a[5:0]};
  endfunction

  function automatic logic [6:0] dd_step(input logic [6:0] a, input logic up, input logic two);
    logic [6:0] r;
    if (two) begin
      if (up) r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
      else    r = (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : a - 7'd1;
    end else begin
      if (up) r = (a == 7'h4F) ? 7'h00 : a + 7'd1;
      else    r = (a == 7'h00) ? 7'h4F : a - 7'd1;
    end
    return r;
  endfunction

  assign s_en   = sync2[10];
  assign s_rs   = sync2[9];
  assign s_rw   = sync2[8];
  assign s_data = sync2[7:0];

  assign fall    = en3 & ~s_en;
  assign wr_acc  = fall & ~s_rw & (state == IDLE);
  assign wr_ovr  = fall & ~s_rw & (state != IDLE);
  assign rd_step = fall & s_rw & s_rs;

  always_comb begin
    if (ac_is_cgram)
      ac_stepped = {1'b0, inc_mode ? ac[5:0] + 6'd1 : ac[5:0] - 6'd1};
    else
      ac_stepped = dd_step(ac, inc_mode, two_line);
  end

  assign rd_byte = ac_is_cgram  ? {3'b000, cgram[ac[5:0]]} :
                   dd_valid(ac) ? ddram[dd_index(ac)] : 8'h20;

  // The clear sweep and data writes never overlap: writes are only accepted in IDLE.
  always_comb begin
    dd_we    = 1'b0;
    dd_waddr = '0;
    dd_wdata = '0;
    cg_we    = 1'b0;
    cg_waddr = '0;
    cg_wdata = '0;
    if (state == CLEAR && sweep < 7'd80) begin
      dd_we    = 1'b1;
      dd_waddr = sweep;
      dd_wdata = 8'h20;
    end else if (wr_acc && s_rs) begin
      if (ac_is_cgram) begin
        cg_we    = 1'b1;
        cg_waddr = ac[5:0];
        cg_wdata = s_data[4:0];
      end else if (dd_valid(ac)) begin
        dd_we    = 1'b1;
        dd_waddr = dd_index(ac);
        dd_wdata = s_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (dd_we) ddram[dd_waddr] <= dd_wdata;
    if (cg_we) cgram[cg_waddr] <= cg_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_char <= '0;
      cg_row    <= '0;
    end else begin
      disp_char <= (disp_addr[5:0] > 6'd39) ? 8'h20 : ddram[dd_index(disp_addr)];
      cg_row    <= cgram[cg_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      en3         <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      sweep       <= '0;
      ac          <= '0;
      ac_is_cgram <= 1'b0;
      display_on  <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      inc_mode    <= 1'b1;
      two_line    <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      cmd_strobe  <= 1'b0;
      data_oe     <= 1'b0;
      data_out    <= '0;
    end else begin
      sync1      <= {enable, rs, rw, data};
      sync2      <= sync1;
      en3        <= s_en;
      cmd_strobe <= wr_acc;
      data_oe    <= s_en & s_rw;
      data_out   <= (s_en & s_rw) ? (s_rs ? rd_byte : {busy, ac}) : '0;
      if (wr_ovr)  overrun <= 1'b1;
      if (rd_step) ac <= ac_stepped;
      case (state)
        IDLE: if (wr_acc) begin
          busy  <= 1'b1;
          state <= EXEC;
          cnt   <= 16'(EXEC_CYCLES - 1);
          if (s_rs) ac <= ac_stepped;
          else begin
            casez (s_data)
              8'b1???_????: begin ac <= s_data[6:0]; ac_is_cgram <= 1'b0; end
              8'b01??_????: begin ac <= {1'b0, s_data[5:0]}; ac_is_cgram <= 1'b1; end
              8'b001?_????: two_line <= s_data[3];
              8'b0001_????: if (!s_data[3]) ac <= dd_step(ac, s_data[2], two_line);
              8'b0000_1???: begin
                display_on <= s_data[2];
                cursor_on  <= s_data[1];
                blink_on   <= s_data[0];
              end
              8'b0000_01??: inc_mode <= s_data[1];
              8'b0000_001?: begin ac <= '0; ac_is_cgram <= 1'b0; end
              8'b0000_0001: begin
                state       <= CLEAR;
                cnt         <= 16'(CLEAR_CYCLES - 1);
                sweep       <= '0;
                ac          <= '0;
                ac_is_cgram <= 1'b0;
                inc_mode    <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        EXEC, CLEAR: begin
          if (state == CLEAR && sweep < 7'd80) sweep <= sweep + 7'd1;
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
